// File: rtl/ifmap_write_addr_gen_if.sv
// Handshake/status bundle between the IFMap write stream and the write address generator.
interface ifmap_write_addr_gen_if #(
  parameter int AW = 5
);
  logic          start;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          wen;
  logic [AW-1:0] WriteAddrIF;
  logic          start_row_ren;
  logic          end_row_ren;
  logic [AW-1:0] start_row;
  logic [AW-1:0] end_row;
  logic          end_row_valid;
  logic          full;
  logic          row_written;

  modport master (
    output start, in_valid, in_last, start_row_ren, end_row_ren,
    input  in_ready, wen, WriteAddrIF, start_row, end_row, end_row_valid, full, row_written
  );

  modport slave (
    input  start, in_valid, in_last, start_row_ren, end_row_ren,
    output in_ready, wen, WriteAddrIF, start_row, end_row, end_row_valid, full, row_written
  );
endinterface

// File: rtl/ifmap_write_addr_gen.sv
// Write-side address generator for the circular IFMap scratchpad: write pointer,
// occupancy tracking and a small queue of completed rows exported to the reader.
module ifmap_write_addr_gen #(
  parameter int IFMap_ADDR_WIDTH = 5,
  parameter int IFMap_DEPTH      = 32,
  parameter int ROWQ_DEPTH       = 4,
  parameter int ROWQ_PTR_WIDTH   = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  ifmap_write_addr_gen_if.slave   s_if
);

  localparam int             AW        = IFMap_ADDR_WIDTH;
  localparam int             PW        = ROWQ_PTR_WIDTH;
  localparam logic [AW:0]    DEPTH_W   = (AW+1)'(IFMap_DEPTH);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(IFMap_DEPTH - 1);
  localparam logic [PW-1:0]  RQ_LAST   = PW'(ROWQ_DEPTH - 1);
  localparam logic [PW:0]    RQ_FULL   = (PW+1)'(ROWQ_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                          r_state;
  logic [AW-1:0]                   r_wptr;
  logic [AW-1:0]                   r_start_row;
  logic [AW-1:0]                   r_end_row;
  logic                            r_end_row_valid;
  logic                            r_row_written;
  logic [AW:0]                     r_occ;
  logic [PW-1:0]                   r_rq_wr;
  logic [PW-1:0]                   r_rq_rd;
  logic [PW:0]                     r_rq_cnt;
  logic [ROWQ_DEPTH-1:0][AW-1:0]   w_rowq;

  logic          w_run;
  logic          w_full;
  logic          w_rq_full;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_push;
  logic          w_release;
  logic [AW-1:0] w_wptr_inc;
  logic [AW-1:0] w_start_next;
  logic [AW:0]   w_diff;
  logic [AW:0]   w_dist;
  logic [AW:0]   w_rowlen;
  logic [AW:0]   w_occ_next;
  logic [PW-1:0] w_rq_wr_inc;
  logic [PW-1:0] w_rq_rd_inc;
  logic [PW-1:0] w_rq_rd_next;
  logic [PW:0]   w_rq_cnt_after_pop;
  logic [PW:0]   w_rq_cnt_next;
  logic [AW-1:0] w_head_next;

  assign w_run      = (r_state == S_RUN);
  assign w_full     = (r_occ == DEPTH_W);
  assign w_rq_full  = (r_rq_cnt == RQ_FULL);
  assign w_in_ready = w_run & ~w_full & ~(w_rq_full & s_if.in_last);
  assign w_accept   = s_if.in_valid & w_in_ready;
  assign w_push     = w_accept & s_if.in_last;
  assign w_release  = w_run & s_if.start_row_ren & s_if.end_row_ren & r_end_row_valid;

  assign w_wptr_inc   = (r_wptr == LAST_ADDR) ? '0 : r_wptr + AW'(1);
  assign w_start_next = (r_end_row == LAST_ADDR) ? '0 : r_end_row + AW'(1);

  // Row length on the ring: biased by DEPTH so the subtraction never goes negative.
  assign w_diff     = {1'b0, r_end_row} + DEPTH_W - {1'b0, r_start_row};
  assign w_dist     = (w_diff >= DEPTH_W) ? w_diff - DEPTH_W : w_diff;
  assign w_rowlen   = w_dist + (AW+1)'(1);
  assign w_occ_next = r_occ + {{AW{1'b0}}, w_accept} - (w_release ? w_rowlen : '0);

  assign w_rq_wr_inc        = (r_rq_wr == RQ_LAST) ? '0 : r_rq_wr + PW'(1);
  assign w_rq_rd_inc        = (r_rq_rd == RQ_LAST) ? '0 : r_rq_rd + PW'(1);
  assign w_rq_rd_next       = w_release ? w_rq_rd_inc : r_rq_rd;
  assign w_rq_cnt_after_pop = r_rq_cnt - {{PW{1'b0}}, w_release};
  assign w_rq_cnt_next      = w_rq_cnt_after_pop + {{PW{1'b0}}, w_push};

  // A row pushed into an otherwise empty queue becomes the head before it lands in storage.
  assign w_head_next = (w_push && (w_rq_cnt_after_pop == '0)) ? r_wptr : w_rowq[w_rq_rd_next];

  generate
    for (genvar gi = 0; gi < ROWQ_DEPTH; gi++) begin : g_rowq
      logic [AW-1:0] r_entry;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_entry <= '0;
        end else if (r_state == S_INIT) begin
          r_entry <= '0;
        end else if (w_push && (r_rq_wr == PW'(gi))) begin
          r_entry <= r_wptr;
        end
      end
      assign w_rowq[gi] = r_entry;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= S_IDLE;
      r_wptr          <= '0;
      r_start_row     <= '0;
      r_end_row       <= '0;
      r_end_row_valid <= 1'b0;
      r_row_written   <= 1'b0;
      r_occ           <= '0;
      r_rq_wr         <= '0;
      r_rq_rd         <= '0;
      r_rq_cnt        <= '0;
    end else begin
      r_row_written <= w_push;
      case (r_state)
        S_IDLE: begin
          if (s_if.start) begin
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_wptr          <= '0;
          r_start_row     <= '0;
          r_end_row       <= '0;
          r_end_row_valid <= 1'b0;
          r_occ           <= '0;
          r_rq_wr         <= '0;
          r_rq_rd         <= '0;
          r_rq_cnt        <= '0;
          if (!s_if.start) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_occ           <= w_occ_next;
          r_rq_cnt        <= w_rq_cnt_next;
          r_rq_rd         <= w_rq_rd_next;
          r_end_row       <= w_head_next;
          r_end_row_valid <= (w_rq_cnt_next != '0);
          if (w_accept) begin
            r_wptr <= w_wptr_inc;
          end
          if (w_push) begin
            r_rq_wr <= w_rq_wr_inc;
          end
          if (w_release) begin
            r_start_row <= w_start_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_if.in_ready      = w_in_ready;
  assign s_if.wen           = w_accept;
  assign s_if.WriteAddrIF   = r_wptr;
  assign s_if.start_row     = r_start_row;
  assign s_if.end_row       = r_end_row;
  assign s_if.end_row_valid = r_end_row_valid;
  assign s_if.full          = w_full;
  assign s_if.row_written   = r_row_written;

endmodule

// File: tb/tb_ifmap_write_addr_gen.sv
// Randomized bench: a row-level reference model predicts status outputs each cycle
// and feeds expected write addresses to a scoreboard drained by a wen monitor.
module tb_ifmap_write_addr_gen;

  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int RQ    = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ifmap_write_addr_gen_if #(.AW(AW)) bus ();

  ifmap_write_addr_gen #(
    .IFMap_ADDR_WIDTH (AW),
    .IFMap_DEPTH      (DEPTH),
    .ROWQ_DEPTH       (RQ),
    .ROWQ_PTR_WIDTH   (2)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .s_if (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 init, 2 run; rows kept as (end address, word count).
  int m_state   = 0;
  int m_wptr    = 0;
  int m_start   = 0;
  int m_occ     = 0;
  int m_cur_len = 0;
  bit m_rw      = 1'b0;
  int m_ends[$];
  int m_lens[$];
  int exp_addr_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_wptr    = 0;
    m_start   = 0;
    m_occ     = 0;
    m_cur_len = 0;
    m_ends.delete();
    m_lens.delete();
  endtask

  // One clock cycle: drive inputs, compare status against the model, advance the model.
  task automatic drive(input bit st, input bit v, input bit l, input bit sr, input bit er);
    bit exp_ready;
    bit accept;
    bit rel;
    @(negedge clk);
    bus.start         = st;
    bus.in_valid      = v;
    bus.in_last       = l;
    bus.start_row_ren = sr;
    bus.end_row_ren   = er;
    #1;
    exp_ready = (m_state == 2) && (m_occ != DEPTH) && !((m_ends.size() == RQ) && l);
    check("in_ready", int'(bus.in_ready), int'(exp_ready));
    check("end_row_valid", int'(bus.end_row_valid), int'(m_ends.size() > 0));
    if (m_ends.size() > 0) check("end_row", int'(bus.end_row), m_ends[0]);
    check("start_row", int'(bus.start_row), m_start);
    check("full", int'(bus.full), int'(m_occ == DEPTH));
    check("row_written", int'(bus.row_written), int'(m_rw));

    accept = v && exp_ready;
    rel    = (m_state == 2) && sr && er && (m_ends.size() > 0);
    if (accept) exp_addr_q.push_back(m_wptr);
    m_rw = accept && l;
    case (m_state)
      0: if (st) m_state = 1;
      1: begin
        model_clear();
        if (!st) m_state = 2;
      end
      default: begin
        if (rel) begin
          m_start = (m_ends[0] + 1) % DEPTH;
          m_occ   = m_occ - m_lens[0];
          void'(m_ends.pop_front());
          void'(m_lens.pop_front());
        end
        if (accept) begin
          m_occ++;
          m_cur_len++;
          if (l) begin
            m_ends.push_back(m_wptr);
            m_lens.push_back(m_cur_len);
            m_cur_len = 0;
          end
          m_wptr = (m_wptr + 1) % DEPTH;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn              = 1'b0;
    bus.start         = 1'b0;
    bus.in_valid      = 1'b1;
    bus.in_last       = 1'b1;
    bus.start_row_ren = 1'b1;
    bus.end_row_ren   = 1'b1;
    #1;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_wen", int'(bus.wen), 0);
    check("rst_WriteAddrIF", int'(bus.WriteAddrIF), 0);
    check("rst_start_row", int'(bus.start_row), 0);
    check("rst_end_row", int'(bus.end_row), 0);
    check("rst_end_row_valid", int'(bus.end_row_valid), 0);
    check("rst_full", int'(bus.full), 0);
    check("rst_row_written", int'(bus.row_written), 0);
    m_state = 0;
    m_rw    = 1'b0;
    model_clear();
    #3;
    rstn = 1'b1;
  endtask

  task automatic restart();
    do_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
  endtask

  // Scoreboard monitor: every write strobe consumes the oldest expected address.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.wen) begin
        if (exp_addr_q.size() == 0) begin
          check("wen_unexpected", 1, 0);
        end else begin
          check("WriteAddrIF", int'(bus.WriteAddrIF), exp_addr_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.start         = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_last       = 1'b0;
    bus.start_row_ren = 1'b0;
    bus.end_row_ren   = 1'b0;
    repeat (3) drive(0, 1, 1, 1, 1);
    rstn = 1'b1;

    // Single 5-word row after a 2-cycle start.
    restart();
    for (int i = 0; i < 5; i++) drive(0, 1, i == 4, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);

    // Rows of 8 without release until full, then one release.
    restart();
    for (int i = 0; i < 36; i++) drive(0, 1, m_cur_len == 7, 0, 0);
    drive(0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) drive(0, 1, m_cur_len == 7, 0, 0);

    // Rows of 8 with continuous release across the address wrap.
    restart();
    for (int i = 0; i < 70; i++) drive(0, 1, m_cur_len == 7, 1, 1);

    // Release coinciding with an accepted in_last word at occupancy 10, rowlen 4.
    restart();
    for (int i = 0; i < 4; i++) drive(0, 1, i == 3, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 1);
    for (int i = 0; i < 28; i++) drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 1);
    for (int i = 0; i < 9; i++) drive(0, 1, 0, 0, 0);

    // Release strobes with an empty queue, and partial strobes with a row present.
    restart();
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, i == 2, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) drive(0, 1, i == 3, 0, 0);

    // Randomized traffic.
    restart();
    for (int i = 0; i < 1500; i++) begin
      bit v;
      bit l;
      v = ($urandom_range(0, 3) != 0);
      l = (m_cur_len >= 7) ? 1'b1 : ($urandom_range(0, 5) == 0);
      drive(0, v, l, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end

    // Reset mid-run with three rows queued.
    restart();
    for (int i = 0; i < 9; i++) drive(0, 1, (i % 3) == 2, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("rows_queued_before_reset", int'(bus.end_row_valid), 1);
    do_reset();
    repeat (3) drive(0, 1, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
